// File: rtl/tapcap_pkg.sv
// Shared types and the round-robin pick helper for the tap capture arbiter.
package tapcap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    // Upper bound on requester count handled by rr_pick.
    localparam int MAX_REQ = 32;

    // One-hot select of the first set bit of valid at or after ptr, cyclic over num bits.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        ptr,
        input int unsigned        num
    );
        logic [MAX_REQ-1:0] pick;
        logic               found;
        int unsigned        idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= num) begin
                idx = idx - num;
            end
            if ((k < num) && !found && valid[idx[4:0]]) begin
                pick[idx[4:0]] = 1'b1;
                found          = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tapcap_if.sv
// Request/capture bundle for tap_capture_arbiter.
// Optional macro TAPCAP_ERR_EN adds cap_err.
interface tapcap_if #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_TAPS = 6,
    parameter int DATA_W   = 8
);
    localparam int TAP_W = $clog2(NUM_TAPS);
    localparam int ID_W  = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*TAP_W-1:0] req_tap;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     cap_valid;
    logic                     cap_ready;
    logic [DATA_W-1:0]        cap_data;
    logic [ID_W-1:0]          cap_id;
    logic [TAP_W-1:0]         cap_tap;
`ifdef TAPCAP_ERR_EN
    logic                     cap_err;

    modport master (
        output req_valid, req_tap, cap_ready,
        input  req_ready, cap_valid, cap_data, cap_id, cap_tap, cap_err
    );
    modport slave (
        input  req_valid, req_tap, cap_ready,
        output req_ready, cap_valid, cap_data, cap_id, cap_tap, cap_err
    );
`else
    modport master (
        output req_valid, req_tap, cap_ready,
        input  req_ready, cap_valid, cap_data, cap_id, cap_tap
    );
    modport slave (
        input  req_valid, req_tap, cap_ready,
        output req_ready, cap_valid, cap_data, cap_id, cap_tap
    );
`endif
endinterface

// File: rtl/tapcap_delay_line.sv
// Register-to-register delay line; stage k is exposed at taps[k*DATA_W +: DATA_W].
module tapcap_delay_line #(
    parameter int DATA_W   = 8,
    parameter int NUM_TAPS = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          in_data,
    output logic [NUM_TAPS*DATA_W-1:0] taps
);

    // Shift every cycle regardless of what the sequencer is doing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else begin
            taps <= {taps[(NUM_TAPS-1)*DATA_W-1:0], in_data};
        end
    end

endmodule

// File: rtl/tap_capture_arbiter.sv
// Round-robin sequencer that launches a sample into the shared delay line and
// returns it from the requested tap. Optional macro TAPCAP_ERR_EN reports
// out-of-range taps through cap_err instead of clamping them.
//
// state | meaning
// IDLE  | offering a round-robin grant on req_ready
// WAIT  | counting down the tap latency
// HOLD  | result presented on cap_*, waiting for cap_ready
module tap_capture_arbiter
    import tapcap_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_TAPS = 6,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    tapcap_if.slave           bus
);
    localparam int TAP_W = $clog2(NUM_TAPS);
    localparam int ID_W  = $clog2(NUM_REQ);

    logic [NUM_TAPS*DATA_W-1:0] taps;
    logic [DATA_W-1:0]          stage_sel;
    state_t                     state;
    logic [ID_W-1:0]            rr_ptr;
    logic [ID_W-1:0]            id_q;
    logic [ID_W-1:0]            acc_id;
    logic [TAP_W-1:0]           tap_q;
    logic [TAP_W-1:0]           cnt;
    logic [TAP_W-1:0]           raw_tap;
    logic [TAP_W-1:0]           acc_tap;
    logic                       acc_oor;
    logic                       err_q;
    logic [MAX_REQ-1:0]         valid_wide;
    logic [MAX_REQ-1:0]         pick_wide;
    logic [NUM_REQ-1:0]         grant;

    tapcap_delay_line #(
        .DATA_W   (DATA_W),
        .NUM_TAPS (NUM_TAPS)
    ) u_delay_line (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .taps    (taps)
    );

    // Round-robin grant, offered only while idle.
    always_comb begin
        valid_wide               = '0;
        valid_wide[NUM_REQ-1:0]  = bus.req_valid;
        pick_wide                = rr_pick(valid_wide, 32'(rr_ptr), 32'(NUM_REQ));
        grant                    = (state == IDLE) ? pick_wide[NUM_REQ-1:0] : '0;
    end

    assign bus.req_ready = grant;

    // Granted requester index and its tap, clamped into the delay line range.
    always_comb begin
        acc_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                acc_id = ID_W'(i);
            end
        end
        raw_tap = bus.req_tap[acc_id*TAP_W +: TAP_W];
        acc_oor = (32'(raw_tap) >= 32'(NUM_TAPS));
        acc_tap = acc_oor ? TAP_W'(NUM_TAPS-1) : raw_tap;
    end

    // An out-of-range tap_q only occurs with err_q set, where the data is forced to zero.
    assign stage_sel = taps[tap_q*DATA_W +: DATA_W];

    // Sequencer: grant, count down the tap latency, hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            id_q          <= '0;
            tap_q         <= '0;
            cnt           <= '0;
            err_q         <= 1'b0;
            bus.cap_valid <= 1'b0;
            bus.cap_data  <= '0;
            bus.cap_id    <= '0;
            bus.cap_tap   <= '0;
`ifdef TAPCAP_ERR_EN
            bus.cap_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        id_q   <= acc_id;
                        rr_ptr <= (32'(acc_id) == NUM_REQ-1) ? '0 : acc_id + 1'b1;
`ifdef TAPCAP_ERR_EN
                        // Bad taps skip the countdown and report on the next edge.
                        tap_q  <= raw_tap;
                        cnt    <= acc_oor ? '0 : raw_tap;
                        err_q  <= acc_oor;
`else
                        tap_q  <= acc_tap;
                        cnt    <= acc_tap;
                        err_q  <= 1'b0;
`endif
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        bus.cap_valid <= 1'b1;
                        bus.cap_data  <= err_q ? '0 : stage_sel;
                        bus.cap_id    <= id_q;
                        bus.cap_tap   <= tap_q;
`ifdef TAPCAP_ERR_EN
                        bus.cap_err   <= err_q;
`endif
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.cap_ready) begin
                        bus.cap_valid <= 1'b0;
`ifdef TAPCAP_ERR_EN
                        bus.cap_err   <= 1'b0;
`endif
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tap_capture_arbiter.sv
// Bench for tap_capture_arbiter: directed table, corner sequences, random vs. transaction model.
module tb_tap_capture_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int NUM_TAPS = 6;
    localparam int DATA_W   = 8;
    localparam int TAP_W    = $clog2(NUM_TAPS);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] in_data = '0;

    tapcap_if #(.NUM_REQ(NUM_REQ), .NUM_TAPS(NUM_TAPS), .DATA_W(DATA_W)) bus ();

    tap_capture_arbiter #(.NUM_REQ(NUM_REQ), .NUM_TAPS(NUM_TAPS), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait (bounded) for a grant; in_data ramps each cycle.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (bus.req_ready != '0) begin
                ok = 1'b1;
                return;
            end
            next_cycle();
            in_data = in_data + 1'b1;
        end
    endtask

    // Wait (bounded) for cap_valid, counting edges; in_data ramps each cycle.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!bus.cap_valid && edges < 20) begin
            next_cycle();
            in_data = in_data + 1'b1;
            edges++;
        end
    endtask

    typedef struct {
        int id;
        int tap;
        int din;
        int exp_lat;
        int exp_tap;
        int exp_data;
        int exp_err;
    } vec_t;

    vec_t vecs[6];

    bit               ok;
    int               lat;
    logic [DATA_W-1:0] acc_data;
    int               edges, vfrom, m_id, m_tap, m_err, ptr, raw, idx;
    bit               busy, exp_cv;
    logic [DATA_W-1:0] m_data;
    logic [NUM_REQ-1:0] exp_rdy;

    initial begin
        vecs[0] = '{0, 3, 'h10, 4, 3, 'h10, 0};
        vecs[1] = '{1, 0, 'h21, 1, 0, 'h21, 0};
        vecs[2] = '{2, 5, 'h5a, 6, 5, 'h5a, 0};
        vecs[3] = '{3, 1, 'hc3, 2, 1, 'hc3, 0};
`ifdef TAPCAP_ERR_EN
        vecs[4] = '{1, 7, 'h77, 1, 7, 'h00, 1};
        vecs[5] = '{2, 6, 'h66, 1, 6, 'h00, 1};
`else
        vecs[4] = '{1, 7, 'h77, 6, 5, 'h77, 0};
        vecs[5] = '{2, 6, 'h66, 6, 5, 'h66, 0};
`endif

        bus.req_valid = '0;
        bus.req_tap   = '0;
        bus.cap_ready = 1'b0;

        // Reset values, then 20 idle cycles.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_cap_valid", bus.cap_valid, 0);
        check("rst_cap_data", bus.cap_data, 0);
        check("rst_cap_id", bus.cap_id, 0);
        check("rst_cap_tap", bus.cap_tap, 0);
        check("rst_req_ready", bus.req_ready, 0);
`ifdef TAPCAP_ERR_EN
        check("rst_cap_err", bus.cap_err, 0);
`endif
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            in_data = in_data + 1'b1;
            #1;
            check("idle_req_ready", bus.req_ready, 0);
            check("idle_cap_valid", bus.cap_valid, 0);
        end

        // All requesters, tap 0: grants 0,1,2,3,0.
        bus.req_valid = 4'b1111;
        bus.req_tap   = '0;
        bus.cap_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_ready(ok);
            check("rr_grant_seen", 32'(ok), 1);
            check("rr_grant", bus.req_ready, 32'(1) << (g % NUM_REQ));
            acc_data = in_data;
            next_cycle();
            in_data = in_data + 1'b1;
            wait_valid(lat);
            check("rr_lat", lat, 1);
            check("rr_data", bus.cap_data, acc_data);
            check("rr_id", bus.cap_id, g % NUM_REQ);
            check("rr_tap", bus.cap_tap, 0);
            if (g == 4) bus.req_valid = '0;
            next_cycle();
            in_data = in_data + 1'b1;
        end
        bus.cap_ready = 1'b0;
        next_cycle();

        // Table: latency, data, id and tap per single request.
        for (int v = 0; v < 6; v++) begin
            bus.req_tap = '0;
            bus.req_tap[vecs[v].id*TAP_W +: TAP_W] = TAP_W'(vecs[v].tap);
            bus.req_valid = '0;
            bus.req_valid[vecs[v].id] = 1'b1;
            in_data = DATA_W'(vecs[v].din);
            #1;
            check("tbl_grant", bus.req_ready, 32'(1) << vecs[v].id);
            next_cycle();
            bus.req_valid = '0;
            in_data = DATA_W'(vecs[v].din + 1);
            wait_valid(lat);
            check("tbl_lat", lat, vecs[v].exp_lat);
            check("tbl_data", bus.cap_data, vecs[v].exp_data);
            check("tbl_id", bus.cap_id, vecs[v].id);
            check("tbl_tap", bus.cap_tap, vecs[v].exp_tap);
`ifdef TAPCAP_ERR_EN
            check("tbl_err", bus.cap_err, vecs[v].exp_err);
`endif
            bus.cap_ready = 1'b1;
            next_cycle();
            #1;
            check("tbl_done", bus.cap_valid, 0);
`ifdef TAPCAP_ERR_EN
            check("tbl_err_clr", bus.cap_err, 0);
`endif
            bus.cap_ready = 1'b0;
        end

        // Stall in HOLD for 10 cycles, then handshake.
        bus.req_tap = '0;
        bus.req_tap[2*TAP_W +: TAP_W] = TAP_W'(1);
        bus.req_valid = 4'b0100;
        in_data = 8'h3c;
        next_cycle();
        bus.req_valid = 4'b1111;
        bus.req_tap = '0;
        in_data = 8'h3d;
        wait_valid(lat);
        check("hold_lat", lat, 2);
        for (int c = 0; c < 10; c++) begin
            #1;
            check("hold_valid", bus.cap_valid, 1);
            check("hold_data", bus.cap_data, 8'h3c);
            check("hold_ready", bus.req_ready, 0);
            next_cycle();
            in_data = in_data + 1'b1;
        end
        bus.cap_ready = 1'b1;
        #1;
        check("hold_hs_valid", bus.cap_valid, 1);
        next_cycle();
        #1;
        check("hold_after_valid", bus.cap_valid, 0);
        check("hold_after_grant", bus.req_ready, 4'b1000);
        bus.req_valid = '0;
        bus.cap_ready = 1'b0;
        next_cycle();

        // Reset during WAIT aborts the capture.
        bus.req_tap = '0;
        bus.req_tap[1*TAP_W +: TAP_W] = TAP_W'(5);
        bus.req_valid = 4'b0010;
        next_cycle();
        bus.req_valid = '0;
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("abort_valid", bus.cap_valid, 0);
        check("abort_data", bus.cap_data, 0);
        check("abort_id", bus.cap_id, 0);
        check("abort_tap", bus.cap_tap, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            #1;
            check("abort_no_valid", bus.cap_valid, 0);
        end
        bus.req_valid = 4'b1111;
        #1;
        check("abort_ptr_reset", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        next_cycle();

        // Random traffic against a timestamped transaction model.
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        busy = 1'b0;
        ptr = 0;
        edges = 0;
        vfrom = 0; m_id = 0; m_tap = 0; m_err = 0; m_data = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            bus.req_valid = NUM_REQ'($urandom);
            bus.req_tap   = (NUM_REQ*TAP_W)'($urandom);
            bus.cap_ready = ($urandom_range(0, 9) < 6);
            in_data       = DATA_W'($urandom);
            #1;
            exp_rdy = '0;
            if (!busy) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    idx = (ptr + j) % NUM_REQ;
                    if (exp_rdy == '0 && bus.req_valid[idx]) exp_rdy[idx] = 1'b1;
                end
            end
            exp_cv = busy && (edges >= vfrom);
            check("rnd_ready", bus.req_ready, exp_rdy);
            check("rnd_valid", bus.cap_valid, exp_cv);
            if (exp_cv) begin
                check("rnd_data", bus.cap_data, m_data);
                check("rnd_id", bus.cap_id, m_id);
                check("rnd_tap", bus.cap_tap, m_tap);
`ifdef TAPCAP_ERR_EN
                check("rnd_err", bus.cap_err, m_err);
`endif
            end
            @(posedge clk);
            edges++;
            if (exp_rdy != '0) begin
                busy = 1'b1;
                for (int j = 0; j < NUM_REQ; j++) if (exp_rdy[j]) m_id = j;
                raw = int'(bus.req_tap[m_id*TAP_W +: TAP_W]);
`ifdef TAPCAP_ERR_EN
                m_err = (raw >= NUM_TAPS) ? 1 : 0;
                m_tap = raw;
`else
                m_err = 0;
                m_tap = (raw >= NUM_TAPS) ? NUM_TAPS - 1 : raw;
`endif
                m_data = (m_err != 0) ? '0 : in_data;
                vfrom = edges + ((m_err != 0) ? 0 : m_tap) + 1;
                ptr = (m_id + 1) % NUM_REQ;
            end else if (exp_cv && bus.cap_ready) begin
                busy = 1'b0;
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
